// File: rtl/t05_flv_pkg.sv
// Shared constants, FSM state encoding and index-to-address mapping for the
// find-least-value pass sequencer.
package t05_flv_pkg;

  localparam int NUM_CHARS = 128;
  localparam int MAX_NODES = 127;
  localparam logic [8:0] NONE_IDX = 9'h180;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_RD,
    S_CMP,
    S_EVAL,
    S_WIPE1,
    S_WIPE2,
    S_WRSUM,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  // Index is {region, slot}; region 1 lives above the character slots.
  function automatic logic [8:0] idx_to_addr(input logic [8:0] index);
    logic [8:0] slot;
    slot = {1'b0, index[7:0]};
    return index[8] ? slot + 9'(NUM_CHARS) : slot;
  endfunction

endpackage

// File: rtl/t05_flv_memport.sv
// Single-request memory port: presents one request at a time and captures the
// read word on the accepting cycle.
module t05_flv_memport #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [8:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              accepted,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [8:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Request fields come from registered FSM state, so they stay put until ack.
  assign mem_req   = req;
  assign mem_wr    = req & wr;
  assign mem_addr  = req ? addr : '0;
  assign mem_wdata = (req & wr) ? wdata : '0;
  assign accepted  = req & mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (accepted && !wr) begin
      rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/t05_flv_sequencer.sv
// Pass-level controller: scans all live entries into the FLV datapath, merges
// the two least entries into a new sum node, and repeats until one remains.
module t05_flv_sequencer
  import t05_flv_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [8:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              flv_clear,
  output logic              comp_valid,
  output logic [DATA_W-1:0] comp_val,
  output logic [8:0]        comp_index,
  input  logic [8:0]        least1,
  input  logic [8:0]        least2,
  input  logic [DATA_W-1:0] sum,
  output logic              node_valid,
  input  logic              node_ready,
  output logic [8:0]        node_left,
  output logic [8:0]        node_right,
  output logic [7:0]        node_id,
  output logic              busy,
  output logic              done,
  output logic [8:0]        root,
  output logic              overflow,
  output logic [3:0]        state_dbg
);

  state_t            state;
  logic [8:0]        idx;
  logic [7:0]        node_cnt;
  logic [8:0]        l1_q, l2_q;
  logic [DATA_W-1:0] s_q;
  logic              eval_wait;
  logic              req_en, req_wr, accepted;
  logic [8:0]        req_addr, idx_off;
  logic [DATA_W-1:0] req_wdata, rd_data;

  always_comb begin
    req_en    = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    case (state)
      S_RD:    begin req_en = 1'b1; req_addr = idx; end
      S_WIPE1: begin req_en = 1'b1; req_wr = 1'b1; req_addr = idx_to_addr(l1_q); end
      S_WIPE2: begin req_en = 1'b1; req_wr = 1'b1; req_addr = idx_to_addr(l2_q); end
      S_WRSUM: begin
        req_en    = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 9'(NUM_CHARS) + {1'b0, node_cnt};
        req_wdata = s_q;
      end
      default: ;
    endcase
  end

  t05_flv_memport #(.DATA_W(DATA_W)) u_memport (
    .clk       (clk),
    .rst       (rst),
    .req       (req_en),
    .wr        (req_wr),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .accepted  (accepted),
    .rdata     (rd_data),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // Handshakes: mem_req/mem_ack and node_valid/node_ready both transfer on the
  // cycle where both are high; the offering side holds every field until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      node_cnt  <= '0;
      l1_q      <= '0;
      l2_q      <= '0;
      s_q       <= '0;
      eval_wait <= 1'b0;
      root      <= NONE_IDX;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          node_cnt <= '0;
          overflow <= 1'b0;
          state    <= S_CLEAR;
        end
        S_CLEAR: begin
          idx   <= '0;
          state <= S_RD;
        end
        S_RD: if (accepted) state <= S_CMP;
        S_CMP: begin
          idx <= idx + 9'd1;
          if (idx + 9'd1 == 9'(NUM_CHARS) + {1'b0, node_cnt}) begin
            eval_wait <= 1'b1;
            state     <= S_EVAL;
          end else begin
            state <= S_RD;
          end
        end
        S_EVAL: begin
          // First cycle lets the datapath register the final entry.
          if (eval_wait) begin
            eval_wait <= 1'b0;
          end else if (least1 == NONE_IDX) begin
            root  <= NONE_IDX;
            state <= S_DONE;
          end else if (least2 == NONE_IDX) begin
            root  <= least1;
            state <= S_DONE;
          end else begin
            l1_q  <= least1;
            l2_q  <= least2;
            s_q   <= sum;
            state <= S_WIPE1;
          end
        end
        S_WIPE1: if (accepted) state <= S_WIPE2;
        S_WIPE2: if (accepted) state <= S_WRSUM;
        S_WRSUM: if (accepted) state <= S_EMIT;
        S_EMIT: if (node_ready) begin
          node_cnt <= node_cnt + 8'd1;
          if (node_cnt + 8'd1 == 8'(MAX_NODES)) begin
            overflow <= 1'b1;
            state    <= S_ERR;
          end else begin
            state <= S_CLEAR;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign idx_off    = idx - 9'(NUM_CHARS);
  assign flv_clear  = (state == S_CLEAR);
  assign comp_valid = (state == S_CMP);
  assign comp_val   = comp_valid ? rd_data : '0;
  assign comp_index = !comp_valid ? 9'd0 :
                      (idx < 9'(NUM_CHARS)) ? {1'b0, idx[7:0]} : {1'b1, idx_off[7:0]};
  assign node_valid = (state == S_EMIT);
  assign node_left  = node_valid ? l1_q : '0;
  assign node_right = node_valid ? l2_q : '0;
  assign node_id    = node_valid ? node_cnt : '0;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE) || (state == S_ERR);
  assign state_dbg  = state;

endmodule

// File: tb/tb_t05_flv_sequencer.sv
// Bench for the FLV pass sequencer: SRAM and FLV datapath stand-ins, a
// whole-build reference model and a per-cycle compare process.
module tb_t05_flv_sequencer;

  localparam int DATA_W = 64;
  localparam logic [8:0] NONE = 9'h180;

  logic              clk, rst, start;
  logic              mem_req, mem_wr, mem_ack;
  logic [8:0]        mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              flv_clear, comp_valid;
  logic [DATA_W-1:0] comp_val, sum;
  logic [8:0]        comp_index, least1, least2;
  logic              node_valid, node_ready;
  logic [8:0]        node_left, node_right, root;
  logic [7:0]        node_id;
  logic              busy, done, overflow;
  logic [3:0]        state_dbg;

  t05_flv_sequencer #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flv_clear(flv_clear), .comp_valid(comp_valid), .comp_val(comp_val),
    .comp_index(comp_index), .least1(least1), .least2(least2), .sum(sum),
    .node_valid(node_valid), .node_ready(node_ready), .node_left(node_left),
    .node_right(node_right), .node_id(node_id), .busy(busy), .done(done),
    .root(root), .overflow(overflow), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bench state ----------------
  logic [DATA_W-1:0] mem [0:255];
  logic [25:0]       exp_q [$];     // {left, right, id}
  logic [72:0]       exp_wr_q [$];  // {addr, data}
  logic [8:0]        exp_root;
  logic              exp_ovf;
  int                exp_reads;
  int                tests, fails;
  int                max_lat, node_stall;
  int                rd_cnt, scan_pos, clr_cnt;
  bit                mon_en, done_seen;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pos_idx(input int p);
    if (p < 128) return 9'(p);
    return 9'h100 | 9'(p - 128);
  endfunction

  // Whole-build reference: repeatedly merge the two smallest live entries,
  // earliest scan position winning ties.
  task automatic run_model();
    logic [DATA_W-1:0] m [0:255];
    logic [DATA_W-1:0] s;
    int nc, n, p1, p2;
    for (int i = 0; i < 256; i++) m[i] = mem[i];
    exp_q.delete();
    exp_wr_q.delete();
    exp_reads = 0;
    exp_ovf   = 1'b0;
    exp_root  = NONE;
    nc = 0;
    while (1) begin
      n  = 128 + nc;
      p1 = -1;
      p2 = -1;
      exp_reads += n;
      for (int p = 0; p < n; p++)
        if (m[p] != 0 && (p1 < 0 || m[p] < m[p1])) p1 = p;
      for (int p = 0; p < n; p++)
        if (p != p1 && m[p] != 0 && (p2 < 0 || m[p] < m[p2])) p2 = p;
      if (p1 < 0) begin exp_root = NONE; break; end
      if (p2 < 0) begin exp_root = pos_idx(p1); break; end
      exp_q.push_back({pos_idx(p1), pos_idx(p2), 8'(nc)});
      s = m[p1] + m[p2];
      exp_wr_q.push_back({9'(p1), 64'h0});
      exp_wr_q.push_back({9'(p2), 64'h0});
      exp_wr_q.push_back({9'(128 + nc), s});
      m[p1] = '0;
      m[p2] = '0;
      m[128 + nc] = s;
      nc++;
      if (nc == 127) begin exp_ovf = 1'b1; break; end
    end
  endtask

  // ---------------- SRAM and tree-writer responders ----------------
  int                lat, nlat;
  bit                pend, npend;
  logic              a_wr;
  logic [8:0]        a_addr;
  logic [DATA_W-1:0] a_wdata;

  initial begin
    mem_ack = 1'b0; mem_rdata = '0; node_ready = 1'b0;
    pend = 1'b0; npend = 1'b0; lat = 0; nlat = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_ack = 1'b0; pend = 1'b0; node_ready = 1'b0; npend = 1'b0;
      end else begin
        if (mem_ack) begin
          if (a_wr) mem[a_addr] = a_wdata;
          mem_ack = 1'b0;
          pend    = 1'b0;
        end
        if (mem_req && !pend) begin
          pend = 1'b1;
          lat  = int'($urandom_range(32'(max_lat), 0));
        end
        if (pend) begin
          if (lat == 0) begin
            mem_ack   = 1'b1;
            a_wr      = mem_wr;
            a_addr    = mem_addr;
            a_wdata   = mem_wdata;
            mem_rdata = mem_wr ? '0 : mem[mem_addr];
          end else lat--;
        end
        if (node_ready) begin node_ready = 1'b0; npend = 1'b0; end
        if (node_valid && !npend) begin npend = 1'b1; nlat = node_stall; end
        if (npend) begin
          if (nlat == 0) node_ready = 1'b1;
          else nlat--;
        end
      end
    end
  end

  // ---------------- FLV datapath stand-in ----------------
  logic [DATA_W-1:0] v1, v2;
  initial begin
    least1 = NONE; least2 = NONE; sum = '0; v1 = '1; v2 = '1;
    forever begin
      @(negedge clk);
      if (flv_clear) begin
        least1 = NONE; least2 = NONE; v1 = '1; v2 = '1;
      end else if (comp_valid && comp_val != 0) begin
        if (comp_val < v1) begin
          least2 = least1; v2 = v1; least1 = comp_index; v1 = comp_val;
        end else if (comp_val < v2) begin
          least2 = comp_index; v2 = comp_val;
        end
      end
      sum = v1 + v2;
    end
  end

  // ---------------- compare process ----------------
  bit                p_mwait, p_nwait, p_mwr;
  logic [8:0]        p_maddr, p_nl, p_nr;
  logic [DATA_W-1:0] p_mwdata;
  logic [7:0]        p_nid;

  initial begin
    p_mwait = 1'b0; p_nwait = 1'b0;
    forever begin
      @(negedge clk);
      if (flv_clear) begin scan_pos = 0; clr_cnt++; end
      if (mon_en) begin
        if (p_mwait)
          chk("mem_hold", {mem_req, mem_wr, mem_addr, mem_wdata}, {1'b1, p_mwr, p_maddr, p_mwdata});
        if (p_nwait)
          chk("node_hold", {node_valid, node_left, node_right, node_id}, {1'b1, p_nl, p_nr, p_nid});
        if (mem_req && mem_ack) begin
          if (mem_wr) begin
            if (exp_wr_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL extra_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
            end else chk("mem_write", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
          end else begin
            chk("rd_addr", mem_addr, 9'(scan_pos));
            rd_cnt++;
          end
        end
        if (comp_valid) begin
          chk("comp_index", comp_index, pos_idx(scan_pos));
          chk("comp_val", comp_val, mem[scan_pos]);
          chk("comp_no_req", mem_req, 1'b0);
          scan_pos++;
        end
        if (node_valid) chk("emit_no_req", mem_req, 1'b0);
        if (node_valid && node_ready) begin
          chk("node_id_max", node_id <= 8'd126, 1'b1);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL extra_record: got %0h/%0h/%0h expected none", node_left, node_right, node_id);
          end else chk("record", {node_left, node_right, node_id}, exp_q.pop_front());
        end
        if (done) begin
          chk("busy_in_done", busy, 1'b1);
          if (!exp_ovf) chk("root", root, exp_root);
          chk("overflow", overflow, exp_ovf);
          chk("records_left", exp_q.size(), 0);
          chk("writes_left", exp_wr_q.size(), 0);
          chk("read_count", rd_cnt, exp_reads);
          done_seen = 1'b1;
        end
      end
      p_mwait  = mon_en && mem_req && !mem_ack;
      p_mwr    = mem_wr;
      p_maddr  = mem_addr;
      p_mwdata = mem_wdata;
      p_nwait  = mon_en && node_valid && !node_ready;
      p_nl     = node_left;
      p_nr     = node_right;
      p_nid    = node_id;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic load_abc();
    clear_mem();
    mem[97] = 64'd5;
    mem[98] = 64'd2;
    mem[99] = 64'd1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic begin_build();
    rd_cnt = 0; scan_pos = 0; clr_cnt = 0; done_seen = 1'b0; mon_en = 1'b1;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic run_build(input int budget, input bit extra_start);
    int cyc;
    begin_build();
    cyc = 0;
    while (!done_seen && cyc < budget) begin
      @(posedge clk); #2;
      start = extra_start && (cyc == 40) && !done_seen;
      cyc++;
    end
    start = 1'b0;
    if (!done_seen) begin
      tests++; fails++;
      $display("FAIL build_timeout: got no done after %0d cycles expected done", budget);
      mon_en = 1'b0;
      do_reset();
    end else begin
      @(negedge clk);
      chk("busy_after_done", busy, 1'b0);
      chk("done_one_cycle", done, 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    tests = 0; fails = 0; max_lat = 0; node_stall = 0; mon_en = 1'b0;
    rst = 1'b1; start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {mem_req, mem_wr, flv_clear, comp_valid, node_valid, busy, done, overflow}, 8'h00);
    chk("rst_root", root, 9'h180);
    chk("rst_fields", {comp_index, node_left, node_right, node_id, mem_addr}, 44'h0);
    chk("rst_data", {comp_val, mem_wdata}, 128'h0);

    // Three-character histogram, zero latency; model pinned by hand values.
    load_abc();
    run_model();
    chk("pin_abc_nrec", exp_q.size(), 2);
    chk("pin_abc_rec0", exp_q[0], {9'h063, 9'h062, 8'd0});
    chk("pin_abc_rec1", exp_q[1], {9'h100, 9'h061, 8'd1});
    chk("pin_abc_nwr", exp_wr_q.size(), 6);
    chk("pin_abc_wr2", exp_wr_q[2], {9'd128, 64'd3});
    chk("pin_abc_wr5", exp_wr_q[5], {9'd129, 64'd8});
    chk("pin_abc_root", exp_root, 9'h101);
    chk("pin_abc_reads", exp_reads, 387);
    run_build(5000, 1'b0);

    // Same histogram with random ack latency, ready stalls, and a stray start.
    load_abc();
    max_lat = 5; node_stall = 3;
    run_model();
    run_build(20000, 1'b1);
    max_lat = 0; node_stall = 0;

    // Single live character.
    clear_mem();
    mem[120] = 64'd7;
    run_model();
    chk("pin_x_root", exp_root, 9'h078);
    chk("pin_x_nrec", exp_q.size() + exp_wr_q.size(), 0);
    chk("pin_x_reads", exp_reads, 128);
    run_build(5000, 1'b0);

    // Empty histogram.
    clear_mem();
    run_model();
    chk("pin_zero_root", exp_root, 9'h180);
    run_build(5000, 1'b0);

    // Random sparse histograms under random latency.
    for (int r = 0; r < 2; r++) begin
      clear_mem();
      for (int k = 0; k < 6; k++) mem[$urandom_range(127, 0)] = 64'($urandom_range(200, 1));
      max_lat = 4; node_stall = int'($urandom_range(3, 0));
      run_model();
      run_build(20000, 1'b0);
    end

    // Reset while reading in the second pass, then rebuild from what SRAM holds.
    load_abc();
    max_lat = 3; node_stall = 0;
    run_model();
    begin_build();
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk); #2;
      if (clr_cnt >= 2 && scan_pos >= 3 && mem_req && !mem_wr) break;
      cyc++;
    end
    if (cyc >= 5000) begin
      tests++; fails++;
      $display("FAIL midpass_wait: got no pass-2 read after %0d cycles expected one", cyc);
    end
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctrl", {busy, mem_req, node_valid, done}, 4'h0);
    chk("midrst_root", root, 9'h180);
    run_model();
    chk("pin_midrst_root", exp_root, 9'h061);
    run_build(10000, 1'b0);

    // 128 equal characters exhaust the node slots.
    clear_mem();
    for (int p = 0; p < 128; p++) mem[p] = 64'd1;
    max_lat = 0; node_stall = 0;
    run_model();
    chk("pin_ovf_nrec", exp_q.size(), 127);
    chk("pin_ovf_flag", exp_ovf, 1'b1);
    run_build(70000, 1'b0);
    @(negedge clk);
    chk("ovf_sticky", overflow, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
